// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute-stage ALU with registered valid/ready output and 2-entry skid
//
// Purpose: evaluates the 4-bit ALUCtrl operation on operands A/B and returns
// result, zero flag and branch-taken flag through an output register backed by
// a one-entry skid register, so one cycle of downstream stall is absorbed.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     upstream handshake (in_ready is a state decode, no path from out_ready)
//   in_ctrl, in_a, in_b     ALUCtrl code and operands, sampled only on accept
//   out_valid / out_ready   downstream handshake
//   out_result, out_zero,   registered result, zero flag, branch flag
//   out_branch
module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ctrl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_branch
);

  // bit0 = OUT valid, bit1 = SKID valid; lets both handshake outputs be plain flop bits
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]       state;
  logic [WIDTH-1:0] skid_result;
  logic             skid_zero;
  logic             skid_branch;

  logic [WIDTH-1:0] alu_result;
  logic             alu_branch;
  logic             alu_zero;
  logic             accept;
  logic             drain;
  logic             a_neg;
  logic             a_is_zero;
  logic             slt;

  assign in_ready  = ~state[1];
  assign out_valid = state[0];
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign a_neg     = in_a[WIDTH-1];
  assign a_is_zero = (in_a == '0);
  assign slt       = ($signed(in_a) < $signed(in_b));

  always_comb begin
    alu_result = '0;
    alu_branch = 1'b0;
    case (in_ctrl)
      4'b0000: alu_result = in_a & in_b;
      4'b0001: alu_result = in_a | in_b;
      4'b0010: alu_result = in_a + in_b;
      4'b0110: alu_result = in_a - in_b;
      4'b0111: alu_result = {{(WIDTH-1){1'b0}}, slt};
      4'b1100: alu_result = ~(in_a | in_b);
      4'b1101: alu_result = in_a ^ in_b;
      // branch codes still produce A-B so BEQ-style zero tests keep working
      4'b1000: begin alu_result = in_a - in_b; alu_branch = (in_a != in_b);        end
      4'b1001: begin alu_result = in_a - in_b; alu_branch = ~a_neg & ~a_is_zero;   end
      4'b1010: begin alu_result = in_a - in_b; alu_branch = a_neg | a_is_zero;     end
      4'b1011: begin alu_result = in_a - in_b; alu_branch = ~a_neg;                end
      4'b1111: begin alu_result = in_a - in_b; alu_branch = a_neg;                 end
      default: begin alu_result = '0;          alu_branch = 1'b0;                  end
    endcase
  end

  // zero is derived from the exact value written into the result register
  assign alu_zero = (alu_result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_branch  <= 1'b0;
      skid_result <= '0;
      skid_zero   <= 1'b0;
      skid_branch <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_result <= alu_result;
            out_zero   <= alu_zero;
            out_branch <= alu_branch;
            state      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_result <= alu_result;
            out_zero   <= alu_zero;
            out_branch <= alu_branch;
          end else if (accept) begin
            // downstream stalled: park the new op behind the held output
            skid_result <= alu_result;
            skid_zero   <= alu_zero;
            skid_branch <= alu_branch;
            state       <= ST_FULL;
          end else if (drain) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            out_result <= skid_result;
            out_zero   <= skid_zero;
            out_branch <= skid_branch;
            state      <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage
module tb_alu_exec_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_ctrl = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_branch;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         b;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_recv   = 0;

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_branch(out_branch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  // Reference: op semantics evaluated with signed integer arithmetic
  function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    e.b = 1'b0;
    case (c)
      4'd0:  e.r = a & b;
      4'd1:  e.r = a | b;
      4'd2:  e.r = W'(sa + sb);
      4'd6:  e.r = W'(sa - sb);
      4'd7:  e.r = (sa < sb) ? 1 : 0;
      4'd12: e.r = ~(a | b);
      4'd13: e.r = a ^ b;
      4'd8:  begin e.r = W'(sa - sb); e.b = (sa != sb); end
      4'd9:  begin e.r = W'(sa - sb); e.b = (sa > 0);   end
      4'd10: begin e.r = W'(sa - sb); e.b = (sa <= 0);  end
      4'd11: begin e.r = W'(sa - sb); e.b = (sa >= 0);  end
      4'd15: begin e.r = W'(sa - sb); e.b = (sa < 0);   end
      default: e.r = '0;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  // One clock: score handshakes seen before the edge, then advance to edge+1
  task automatic cycle(output bit acc);
    exp_t e;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("spurious_output", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("result", out_result, e.r);
        chk("zero", out_zero, e.z);
        chk("branch", out_branch, e.b);
        n_recv++;
      end
    end
    if (acc) expq.push_back(model(in_ctrl, in_a, in_b));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] er, input logic ez, input logic eb);
    bit acc;
    in_valid = 1'b1; in_ctrl = c; in_a = a; in_b = b; out_ready = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    chk({tag, "_acc"}, acc, 1);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_res"}, out_result, er);
    chk({tag, "_zero"}, out_zero, ez);
    chk({tag, "_br"}, out_branch, eb);
    cycle(acc);
  endtask

  initial begin
    bit acc;
    logic [W-1:0] held;
    int budget;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_branch", out_branch, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    send("slt",      4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    send("sub_eq",   4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0);
    send("bgtz0",    4'b1001, 32'd0, 32'd7, 32'hFFFF_FFF9, 1'b0, 1'b0);
    send("blez0",    4'b1010, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    send("bltz_min", 4'b1111, 32'h8000_0000, 32'd0, 32'h8000_0000, 1'b0, 1'b1);
    send("bne",      4'b1000, 32'd3, 32'd4, 32'hFFFF_FFFF, 1'b0, 1'b1);
    send("bad_code", 4'b0011, 32'd9, 32'd2, 32'd0, 1'b1, 1'b0);
    send("nor",      4'b1100, 32'h0F0F_0000, 32'h0000_00FF, 32'hF0F0_FF00, 1'b0, 1'b0);
    send("bgez_pos", 4'b1011, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1);

    // Stall: X, Y accepted, Z held off until downstream drains
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 4'b0010; in_a = 32'd10; in_b = 32'd1;
    cycle(acc); chk("stall_x_acc", acc, 1);
    in_ctrl = 4'b0110; in_a = 32'd20; in_b = 32'd3;
    cycle(acc); chk("stall_y_acc", acc, 1);
    in_ctrl = 4'b1101; in_a = 32'hA5A5_A5A5; in_b = 32'hFFFF_0000;
    chk("stall_ready_low", in_ready, 0);
    held = out_result;
    cycle(acc); chk("stall_z_blocked", acc, 0);
    cycle(acc);
    chk("stall_hold_result", out_result, held);
    chk("stall_hold_x", out_result, 32'd11);
    chk("stall_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    n_recv = 0;
    budget = 0;
    while ((in_valid || expq.size() != 0) && budget < 20) begin
      cycle(acc);
      if (acc) in_valid = 1'b0;
      budget++;
    end
    chk("stall_drain_done", budget < 20, 1);
    chk("stall_recv_count", n_recv, 3);

    // Streaming random ops with downstream always ready
    n_recv = 0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_ctrl = 4'($urandom_range(0, 15));
      in_a = $urandom;
      in_b = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
      if ($urandom_range(0, 7) == 0) in_a = 32'h8000_0000;
      cycle(acc);
      chk("stream_acc", acc, 1);
      chk("stream_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    cycle(acc);
    chk("stream_recv_count", n_recv, 100);
    chk("stream_empty", expq.size(), 0);

    // Reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 4'b0001; in_a = 32'h1234; in_b = 32'h0F00;
    cycle(acc);
    cycle(acc);
    in_valid = 1'b0;
    chk("full_before_rst", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_result", out_result, 0);
    chk("arst_zero", out_zero, 0);
    chk("arst_branch", out_branch, 0);
    expq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send("post_rst", 4'b1101, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b0, 1'b0);
    chk("post_rst_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
